// File: rtl/riscv_defines.sv
// Shared RISC-V fetch-path constants.
//   `RISCV_WORD_WIDTH : fetch/instruction word width (32)
//   `RISCV_ADDR_WIDTH : address width (32)
//   riscv_defines_pkg::RISCV_OPC_32BIT : low two opcode bits marking a 32-bit instruction
`ifndef RISCV_DEFINES_SV
`define RISCV_DEFINES_SV

`define RISCV_WORD_WIDTH 32
`define RISCV_ADDR_WIDTH 32

package riscv_defines_pkg;
  localparam logic [1:0] RISCV_OPC_32BIT = 2'b11;
endpackage

`endif

// File: rtl/prefetch_realign_buffer.sv
// Prefetch realignment buffer: accepts 32-bit fetch words and presents
// complete 16/32-bit instructions, including 32-bit instructions that
// straddle two fetch words or the storage wrap.
//   clk, rst_n (async, active-low)
//   flush_i, flush_addr_i           : discard contents, restart at address
//   fetch_valid_i/fetch_ready_o     : fetch word handshake, fetch_data_i
//   instr_valid_o/instr_ready_i     : instruction handshake
//   instr_o, compressed_o, addr_o   : presented instruction
//   level_o                         : valid halfwords held
`ifndef RISCV_DEFINES_SV
`include "riscv_defines.sv"
`endif

module prefetch_realign_buffer
  import riscv_defines_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned WORD_WIDTH = `RISCV_WORD_WIDTH,
  parameter int unsigned ADDR_WIDTH = `RISCV_ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_i,
  input  logic [ADDR_WIDTH-1:0]       flush_addr_i,
  input  logic                        fetch_valid_i,
  output logic                        fetch_ready_o,
  input  logic [WORD_WIDTH-1:0]       fetch_data_i,
  output logic                        instr_valid_o,
  input  logic                        instr_ready_i,
  output logic [WORD_WIDTH-1:0]       instr_o,
  output logic                        compressed_o,
  output logic [ADDR_WIDTH-1:0]       addr_o,
  output logic [$clog2(2*DEPTH):0]    level_o
);

  localparam int unsigned HW_N  = 2 * DEPTH;
  localparam int unsigned IDX_W = $clog2(HW_N);
  localparam int unsigned WP_W  = $clog2(DEPTH) + 1;
  localparam int unsigned RP_W  = IDX_W + 1;

  logic [WP_W-1:0]       r_wr_ptr;
  logic [RP_W-1:0]       r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_mem [HW_N];

  logic [RP_W-1:0]  w_diff;
  logic             w_underrun;
  logic [RP_W-1:0]  w_level;
  logic [WP_W-1:0]  w_words_used;
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_rd_idx1;
  logic [15:0]      w_hw0;
  logic [15:0]      w_hw1;
  logic             w_compressed;
  logic             w_valid;
  logic             w_wr_en;
  logic             w_rd_en;
  logic [WP_W-2:0]  w_slot;

  // Availability 2*wr - rd; the only negative value reachable is -1
  // (misaligned flush, nothing written yet), which shows up as all ones.
  assign w_diff       = {r_wr_ptr, 1'b0} - r_rd_ptr;
  assign w_underrun   = (w_diff == '1);
  assign w_level      = w_underrun ? '0 : w_diff;
  assign w_words_used = r_wr_ptr - r_rd_ptr[RP_W-1:1];

  assign w_rd_idx     = r_rd_ptr[IDX_W-1:0];
  assign w_rd_idx1    = w_rd_idx + IDX_W'(1);
  assign w_hw0        = r_mem[w_rd_idx];
  assign w_hw1        = r_mem[w_rd_idx1];
  assign w_compressed = (w_hw0[1:0] != RISCV_OPC_32BIT);
  assign w_valid      = w_compressed ? (w_level != '0) : (w_level >= RP_W'(2));

  assign w_wr_en = fetch_valid_i && fetch_ready_o && !flush_i;
  assign w_rd_en = w_valid && instr_ready_i;
  assign w_slot  = r_wr_ptr[WP_W-2:0];

  assign fetch_ready_o = (w_words_used < WP_W'(DEPTH));
  assign instr_valid_o = w_valid;
  assign compressed_o  = w_compressed;
  assign instr_o       = w_compressed ? {16'h0000, w_hw0} : {w_hw1, w_hw0};
  assign addr_o        = r_addr;
  assign level_o       = w_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_addr   <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= {{(RP_W-1){1'b0}}, flush_addr_i[1]};
      r_addr   <= flush_addr_i & ~ADDR_WIDTH'(1);
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + WP_W'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + (w_compressed ? RP_W'(1) : RP_W'(2));
        r_addr   <= r_addr + (w_compressed ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));
      end
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[{w_slot, 1'b0}] <= fetch_data_i[15:0];
      r_mem[{w_slot, 1'b1}] <= fetch_data_i[31:16];
    end
  end

endmodule

// File: doc/prefetch_realign_buffer.md
PREFETCH_REALIGN_BUFFER -- requirements
Module: prefetch_realign_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, storage depth in 32-bit words; legal values are powers of 2 that are at least 2.
REQ-002 SHALL have parameter WORD_WIDTH, default `RISCV_WORD_WIDTH (32), fetch word width; fixed at 32.
REQ-003 SHALL have parameter ADDR_WIDTH, default `RISCV_ADDR_WIDTH (32), address width.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 flush_i  in  1  discard contents and restart at flush_addr_i.
REQ-007 flush_addr_i  in  ADDR_WIDTH  restart address; bit 0 ignored.
REQ-008 fetch_valid_i  in  1  fetch word offered.
REQ-009 fetch_ready_o  out  1  a word slot is free.
REQ-010 fetch_data_i  in  WORD_WIDTH  fetch word; bits [15:0] are the lower-address halfword.
REQ-011 instr_valid_o  out  1  a complete instruction is presented.
REQ-012 instr_ready_i  in  1  consumer takes the presented instruction.
REQ-013 instr_o  out  WORD_WIDTH  instruction; compressed instructions are zero-extended in [31:16].
REQ-014 compressed_o  out  1  presented instruction is 16-bit.
REQ-015 addr_o  out  ADDR_WIDTH  address of the presented instruction.
REQ-016 level_o  out  $clog2(2*DEPTH)+1  valid halfwords held.

Function
REQ-017 Storage: 2*DEPTH halfwords; word write pointer of $clog2(DEPTH)+1 bits (wrap bit); halfword read pointer of $clog2(2*DEPTH)+1 bits.
REQ-018 Write accepted when fetch_valid_i && fetch_ready_o && !flush_i; both halfwords stored at the write slot; write pointer increments by 1 modulo 2*DEPTH.
REQ-019 fetch_ready_o = (write ptr - read ptr[MSB:1]) mod 2*DEPTH < DEPTH; combinational from registered state only, with no dependence on instr_ready_i.
REQ-020 Halfword availability A = 2*wr_ptr - rd_ptr, signed; A = -1 occurs only after a misaligned flush; level_o = max(A, 0).
REQ-021 Length decode: halfword at the read pointer is compressed iff bits [1:0] != 2'b11.
REQ-022 instr_valid_o = (compressed && A>=1) || (!compressed && A>=2); the outputs are combinational from registered state.
REQ-023 A 32-bit instruction is {hw[rd+1], hw[rd]}, with indices taken modulo 2*DEPTH; straddling the storage wrap SHALL work.
REQ-024 Read handshake: when instr_valid_o && instr_ready_i, the read pointer advances by 1 for compressed or 2 otherwise, and addr_o advances by 2 or 4 (wrapping at 2^ADDR_WIDTH).
REQ-025 When instr_valid_o is low, instr_ready_i SHALL be ignored; instr_o, compressed_o and addr_o remain stable while instr_valid_o is high and not consumed.
REQ-026 Latency: a word accepted in cycle N is readable from cycle N+1; read and write in the same cycle are both honoured, including when fetch_ready_o is low and a read frees space (the freed slot becomes writable from the next cycle).
REQ-027 Flush has priority over read and write in the same cycle. Next state: wr_ptr=0; rd_ptr={0, flush_addr_i[1]}; addr_o=flush_addr_i with bit 0 cleared; any write in the flush cycle is dropped.
REQ-028 Misaligned restart: with flush_addr_i[1]=1, the first word written after the flush supplies only its upper halfword; A becomes 1.
REQ-029 Consecutive flushes: the last one wins; a flush while empty is legal.

Reset
REQ-030 While rst_n is low: pointers = 0; addr_o = 0; instr_valid_o = 0; fetch_ready_o = 1; level_o = 0.
REQ-031 Storage contents are not reset; instr_o and compressed_o are don't-care while instr_valid_o = 0.
REQ-032 Reset asserted mid-operation SHALL discard all contents immediately and asynchronously.

Structure
REQ-033 Width constants SHALL come from riscv_defines.sv; the compressed-opcode test (2'b11) SHALL be a shared constant there.
REQ-034 The block SHALL be a single module with no sub-module; length decode is inline logic.

Verification
REQ-035 Reset, flush to 0x100, write 0x00A3_0293 then 0x4501_4581 -> 32-bit 0x00A30293 @0x100, then compressed 0x4581 @0x104, then 0x4501 @0x106; instr_valid_o = 0 afterwards.
REQ-036 Flush to 0x202, write 0x0013_4501 -> compressed 0x00000013? No: first output is upper halfword 0x0013 treated as a 32-bit head; instr_valid_o = 0 until the next word arrives; write 0x0000_0005 -> 0x00050013 @0x202.
REQ-037 DEPTH=4, fill 4 words with no reads -> fetch_ready_o = 0 and level_o = 8; one 32-bit read -> fetch_ready_o = 1 next cycle; a write offered while full is not taken.
REQ-038 A 32-bit instruction straddling halfwords 7 and 0 -> correct concatenation and addr_o continuity across the wrap.
REQ-039 Flush, fetch_valid_i and instr_ready_i in the same cycle -> buffer empty, write dropped, addr_o = flush target.
REQ-040 rst_n pulsed low while 3 words are held -> instr_valid_o = 0, level_o = 0 and fetch_ready_o = 1 without waiting for a clock edge.
